// File: rtl/pipe_types_pkg.sv
// -----------------------------------------------------------------------------
// pipe_types_pkg
//
// Shared types for the elastic pipeline-stage registers:
//   - skid_state_t : occupancy state of the two-entry skid buffer
//   - per-stage payload structs (IF/ID, ID/EX, EX/MEM, MEM/WB). An instantiator
//     passes $bits(<struct>) as WIDTH and the bit position of the struct's halt
//     field as HALT_IDX. Every struct below keeps halt in its MSB.
//   - stall counter width / saturation value and a saturating increment helper
// -----------------------------------------------------------------------------
package pipe_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entry held
        ONE   = 2'd1,   // main entry valid
        TWO   = 2'd2    // main and skid entries valid
    } skid_state_t;

    localparam int          STALL_W   = 32;
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    // Saturating increment for the performance stall counter.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] value);
        return (value == STALL_MAX) ? value : value + 32'd1;
    endfunction

    typedef struct packed {
        logic        halt;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        halt;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic        halt;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic        halt;
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//
// Two-entry skid buffer: a main register (what downstream sees), a skid
// register that catches one extra entry while downstream stalls, and the
// EMPTY/ONE/TWO occupancy FSM. Because a second slot always exists while in
// ONE, ready can be registered and still sustain one entry per cycle.
//
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   synchronous active-low reset
//   flush      in   squash both entries, load BUBBLE, go EMPTY
//   push       in   an entry is accepted this cycle (already qualified by ready)
//   push_data  in   payload of the accepted entry
//   pop        in   the main entry is emitted this cycle (qualified by valid)
//   ready      out  registered: 1 unless the buffer is in TWO
//   valid      out  main entry present
//   data       out  main entry payload
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_types_pkg::*;
#(
    parameter int               WIDTH  = 128,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = push_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            // Downstream stalled: park the new entry behind main.
                            skid_d  = push_data;
                            state_d = TWO;
                        end
                        2'b11: main_d  = push_data;
                        2'b01: state_d = EMPTY;   // main keeps last emitted value
                        default: ;
                    endcase
                end
                TWO: begin
                    // ready is low in TWO, so only a pop can happen here.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Registered ready tracks the state being entered at this edge.
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign valid = (state_q != EMPTY);
    assign data  = main_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// Elastic register between two CPU pipeline stages. Carries an opaque payload
// with a valid/ready handshake, supports a synchronous flush that loads a NOP
// bubble, latches a sticky halt when a halt-flagged entry is accepted, and
// counts stall cycles (out_valid && !out_ready) with saturation.
//
// Parameters:
//   WIDTH     payload width (pass $bits of the stage struct)
//   SKID      0: single register, combinational in_ready
//             1: two-entry skid buffer, registered in_ready
//   BUBBLE    payload loaded on reset and flush
//   HALT_IDX  bit index of the halt flag inside the payload
//
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   synchronous active-low reset
//   flush      in   squash all held entries
//   in_valid   in   upstream entry present
//   in_ready   out  stage accepts this cycle
//   in_data    in   upstream payload
//   out_valid  out  downstream entry present
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload to next stage
//   halted     out  sticky halt-entry-accepted flag
//   stall_cnt  out  saturating count of stalled output cycles
// -----------------------------------------------------------------------------
module pipeline_stage_reg
    import pipe_types_pkg::*;
#(
    parameter int               WIDTH    = 128,
    parameter int               SKID     = 1,
    parameter logic [WIDTH-1:0] BUBBLE   = '0,
    parameter int               HALT_IDX = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             halted,
    output logic [31:0]      stall_cnt
);

    // Mask form of the halt bit keeps the select width-clean for any WIDTH.
    localparam logic [WIDTH-1:0] HALT_MASK = WIDTH'(1) << HALT_IDX;

    logic             stage_valid;
    logic             stage_ready;   // storage readiness, before halt gating
    logic [WIDTH-1:0] stage_data;
    logic             accept;
    logic             emit;

    logic               halted_q, halted_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Once halted, nothing new enters until reset; held entries still drain.
    assign in_ready = stage_ready && !halted_q;
    assign accept   = in_valid && in_ready;
    assign emit     = stage_valid && out_ready;

    generate
        if (SKID != 0) begin : gen_skid
            pipe_skid_buf #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid_buf (
                .CLK       (CLK),
                .nRST      (nRST),
                .flush     (flush),
                .push      (accept),
                .push_data (in_data),
                .pop       (emit),
                .ready     (stage_ready),
                .valid     (stage_valid),
                .data      (stage_data)
            );
        end else begin : gen_single
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] data_q, data_d;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (flush) begin
                    valid_d = 1'b0;
                    data_d  = BUBBLE;
                end else if (accept) begin
                    // Covers both fill-from-empty and replace-while-emitting.
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (emit) begin
                    valid_d = 1'b0;   // data_q keeps the last emitted value
                end
            end

            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    valid_q <= 1'b0;
                    data_q  <= BUBBLE;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign stage_valid = valid_q;
            assign stage_data  = data_q;
            assign stage_ready = !valid_q || out_ready;
        end
    endgenerate

    always_comb begin
        halted_d = halted_q;
        // A flush discards the offered entry, including a halt entry.
        if (!flush && accept && |(in_data & HALT_MASK)) begin
            halted_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stage_valid && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = stage_valid;
    assign out_data  = stage_data;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule
